// File: rtl/sync_fifo_param_pkg.sv
// Shared helpers for the parametrised FIFO: width arithmetic and
// configuration sanity checks evaluated at elaboration time.
package fifo_pkg;

  // Smallest n such that 2**n >= v (clog2(1) = 0).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // DEPTH must be a power of two so the pointers wrap by simple overflow.
  function automatic bit depth_ok(input int unsigned depth);
    return (depth >= 2) && is_pow2(depth);
  endfunction

  function automatic bit af_ok(input int af_level, input int depth);
    return (af_level >= 1) && (af_level <= depth);
  endfunction

  function automatic bit ae_ok(input int ae_level, input int depth);
    return (ae_level >= 0) && (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param. The master side drives
// requests and data; the slave side (the FIFO) drives data out and status.
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = clog2(DEPTH + 1);

  logic             push;
  logic [WIDTH-1:0] write_data;
  logic             pop;
  logic [WIDTH-1:0] read_data;
  logic             read_valid;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             clr_err;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, write_data, pop, clr_err,
    input  read_data, read_valid, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );

  modport slave (
    input  push, write_data, pop, clr_err,
    output read_data, read_valid, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_param_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous
// read address port. Contents are deliberately not reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store the word on an accepted push.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds, sticky overflow/underflow flags and a selectable read mode
// (registered read or first-word-fall-through).
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3,
  parameter int AE_LEVEL = 1,
  parameter int FWFT     = 0
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_param_if.slave bus
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  localparam bit DEPTH_OK = depth_ok(DEPTH);
  localparam bit AF_OK    = af_ok(AF_LEVEL, DEPTH);
  localparam bit AE_OK    = ae_ok(AE_LEVEL, DEPTH);

  if (!DEPTH_OK) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and >= 2");
  end
  if (!AF_OK) begin : g_bad_af
    $error("sync_fifo_param: AF_LEVEL must be in 1..DEPTH");
  end
  if (!AE_OK) begin : g_bad_ae
    $error("sync_fifo_param: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] ram_rdata;
  logic             empty;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  // Status decodes come from the registered count only, so they trail the
  // causing edge by one cycle and never depend on the current requests.
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));

  // A pop on a full FIFO frees a slot in the same edge, so a simultaneous
  // push is still accepted.
  assign pop_ok  = bus.pop & ~empty;
  assign push_ok = bus.push & (~full | pop_ok);

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_reg),
    .wdata (bus.write_data),
    .raddr (rd_ptr_reg),
    .rdata (ram_rdata)
  );

  // Next-state for pointers, occupancy and the sticky error flags.
  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg & ~bus.clr_err;
    underflow_next = underflow_reg & ~bus.clr_err;

    if (push_ok) wr_ptr_next = wr_ptr_reg + PW'(1);
    if (pop_ok)  rd_ptr_next = rd_ptr_reg + PW'(1);

    if (push_ok && !pop_ok)      count_next = count_reg + CW'(1);
    else if (pop_ok && !push_ok) count_next = count_reg - CW'(1);

    // A new error event beats a coincident clear.
    if (bus.push && !push_ok) overflow_next  = 1'b1;
    if (bus.pop && empty)     underflow_next = 1'b1;
  end

  // State register; reset discards contents by zeroing pointers and count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Last word handed out; in registered mode this is the output register,
  // in FWFT mode it holds read_data steady while the FIFO is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         data_reg <= '0;
    else if (pop_ok) data_reg <= ram_rdata;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is visible without a pop whenever there is one.
    assign bus.read_data  = empty ? data_reg : ram_rdata;
    assign bus.read_valid = ~empty;
  end else begin : g_registered
    logic valid_reg;

    // One-cycle valid pulse following each accepted pop.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) valid_reg <= 1'b0;
      else     valid_reg <= pop_ok;
    end

    assign bus.read_data  = data_reg;
    assign bus.read_valid = valid_reg;
  end

  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_empty = (count_reg <= CW'(AE_LEVEL));
  assign bus.almost_full  = (count_reg >= CW'(AF_LEVEL));
  assign bus.count        = count_reg;
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;

endmodule
